// File: rtl/alu_mp_sequencer.sv
// alu_mp_sequencer
//   Sequences multi-precision ADD/SUB over a shared 8-bit ALU, one byte per
//   cycle, LSB first. The carry/borrow chain lives in the ALU's own clocked
//   carry register. The sequencer clears that register with an XOR 0^0 cycle
//   before the first byte.
//   Optional feature macro: MP_CARRY_OUT_EN. When it is defined, one extra
//   cycle after the last byte reads the final carry/borrow out of the ALU.
//   Without it, rsp_carry is tied to 0.
//   All outputs come from registers. The ALU drive values are computed from
//   the next state, so each state presents its operands during its own cycle.
module alu_mp_sequencer #(
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_op,
    input  logic [LEN_W-1:0]       req_len,
    input  logic [MAX_BYTES*8-1:0] req_a,
    input  logic [MAX_BYTES*8-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [MAX_BYTES*8-1:0] rsp_result,
    output logic                   rsp_zero,
    output logic                   rsp_carry,
    output logic                   busy,
    output logic [3:0]             alu_op,
    output logic [7:0]             alu_dat_a,
    output logic [7:0]             alu_dat_b,
    output logic [2:0]             alu_imm,
    input  logic [7:0]             alu_rslt,
    input  logic                   alu_zero
);

    localparam int DW = MAX_BYTES * 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_BYTE  = 3'd2,
        S_CARRY = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Pick byte i out of a multi-byte operand.
    function automatic logic [7:0] byte_sel(input logic [DW-1:0] v, input logic [LEN_W-1:0] i);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < MAX_BYTES; k++) begin
            r = (LEN_W'(k) == i) ? v[k*8 +: 8] : r;
        end
        return r;
    endfunction

    // Replace byte i of a multi-byte word with d.
    function automatic logic [DW-1:0] byte_put(input logic [DW-1:0] v, input logic [LEN_W-1:0] i,
                                               input logic [7:0] d);
        logic [DW-1:0] r;
        r = v;
        for (int k = 0; k < MAX_BYTES; k++) begin
            r[k*8 +: 8] = (LEN_W'(k) == i) ? d : v[k*8 +: 8];
        end
        return r;
    endfunction

    // Lengths above MAX_BYTES are treated as MAX_BYTES.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : l;
    endfunction

    // Map request op (0=ADD, 1=SUB) to the ALU opcode.
    function automatic logic [3:0] arith_op(input logic op);
        return op ? 4'b0010 : 4'b0001;
    endfunction

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [DW-1:0]     a_q, a_d;
    logic [DW-1:0]     b_q, b_d;
    logic [DW-1:0]     result_q, result_d;
    logic              zero_q, zero_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [7:0]        alu_a_q, alu_a_d;
    logic [7:0]        alu_b_q, alu_b_d;
`ifdef MP_CARRY_OUT_EN
    logic              carry_q, carry_d;
`endif

    // Next-state logic for the sequencer FSM and its datapath registers.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        len_d    = len_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef MP_CARRY_OUT_EN
        carry_d  = carry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    len_d    = clamp_len(req_len);
                    a_d      = req_a;
                    b_d      = req_b;
                    result_d = '0;
                    zero_d   = 1'b1;
                    idx_d    = '0;
`ifdef MP_CARRY_OUT_EN
                    carry_d  = 1'b0;
`endif
                    state_d  = S_CLR;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CLR: begin
                if (len_q == '0) begin
                    result_d = '0;
                    zero_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_BYTE;
                end
            end
            S_BYTE: begin
                result_d = byte_put(result_q, idx_q, alu_rslt);
                zero_d   = zero_q & alu_zero;
                idx_d    = idx_q + LEN_W'(1);
                if (idx_q == len_q - LEN_W'(1)) begin
`ifdef MP_CARRY_OUT_EN
                    state_d = S_CARRY;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_BYTE;
                end
            end
`ifdef MP_CARRY_OUT_EN
            S_CARRY: begin
                // ADD with 0/0 yields carryIn; SUB with 0/0 yields 0xFF on borrow.
                carry_d = alu_rslt[0];
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered handshake and ALU drive values, derived from the next state.
    always_comb begin
        rsp_valid_d = (state_d == S_DONE);
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        alu_op_d    = 4'b0000;
        alu_a_d     = 8'h00;
        alu_b_d     = 8'h00;
        if (state_d == S_BYTE) begin
            alu_op_d = arith_op(op_d);
            alu_a_d  = byte_sel(a_d, idx_d);
            alu_b_d  = byte_sel(b_d, idx_d);
`ifdef MP_CARRY_OUT_EN
        end else if (state_d == S_CARRY) begin
            alu_op_d = arith_op(op_d);
            alu_a_d  = 8'h00;
            alu_b_d  = 8'h00;
`endif
        end else begin
            // XOR 0^0 keeps the ALU carry register cleared.
            alu_op_d = 4'b0000;
            alu_a_d  = 8'h00;
            alu_b_d  = 8'h00;
        end
    end

    // State and datapath registers; async reset aborts any operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= 1'b0;
            len_q       <= '0;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            alu_op_q    <= 4'b0000;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
`ifdef MP_CARRY_OUT_EN
            carry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
`ifdef MP_CARRY_OUT_EN
            carry_q     <= carry_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign busy       = busy_q;
    assign alu_op     = alu_op_q;
    assign alu_dat_a  = alu_a_q;
    assign alu_dat_b  = alu_b_q;
    assign alu_imm    = 3'b000;
`ifdef MP_CARRY_OUT_EN
    assign rsp_carry  = carry_q;
`else
    assign rsp_carry  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Testbench for alu_mp_sequencer: ALU model with clocked carry, scoreboard
// queue filled at request accept, monitor comparing on every response cycle.
// Honours MP_CARRY_OUT_EN the same way as the design.
module tb_alu_mp_sequencer;

    localparam int MB = 4;
    localparam int LW = 3;
`ifdef MP_CARRY_OUT_EN
    localparam int EXTRA = 1;
    localparam bit EN    = 1'b1;
`else
    localparam int EXTRA = 0;
    localparam bit EN    = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [LW-1:0] req_len;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_result;
    logic          rsp_zero;
    logic          rsp_carry;
    logic          busy;
    logic [3:0]    alu_op;
    logic [7:0]    alu_dat_a;
    logic [7:0]    alu_dat_b;
    logic [2:0]    alu_imm;
    logic [7:0]    alu_rslt;
    logic          alu_zero;

    alu_mp_sequencer #(.MAX_BYTES(MB), .LEN_W(LW)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_len   (req_len),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry),
        .busy      (busy),
        .alu_op    (alu_op),
        .alu_dat_a (alu_dat_a),
        .alu_dat_b (alu_dat_b),
        .alu_imm   (alu_imm),
        .alu_rslt  (alu_rslt),
        .alu_zero  (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- ALU model: combinational result, carry register clocked ----
    bit         alu_c;
    logic       alu_cn;
    logic [8:0] t9;
    always_comb begin
        t9     = 9'h000;
        alu_cn = 1'b0;
        case (alu_op)
            4'b0001: begin t9 = {1'b0, alu_dat_a} + {1'b0, alu_dat_b} + {8'h00, alu_c}; alu_cn = t9[8]; end
            4'b0010: begin t9 = {1'b0, alu_dat_a} - {1'b0, alu_dat_b} - {8'h00, alu_c}; alu_cn = t9[8]; end
            default: begin t9 = {1'b0, alu_dat_a ^ alu_dat_b}; alu_cn = 1'b0; end
        endcase
        alu_rslt = t9[7:0];
        alu_zero = (t9[7:0] == 8'h00);
    end
    always @(posedge clk) alu_c <= alu_cn;

    // ---- scoreboard ----
    typedef struct {
        logic [31:0] res;
        bit          zero;
        bit          carry;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sbq[$];

    int vectors = 0;
    int miscompares = 0;
    bit hold_rdy = 1'b0;
    bit force_rdy = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference: whole-number arithmetic on the first eff bytes.
    function automatic exp_t model(input bit op, input int len, input logic [31:0] a,
                                   input logic [31:0] b, input int acc);
        exp_t e;
        int eff;
        longint unsigned mask, am, bm, r;
        eff  = (len > MB) ? MB : len;
        mask = (eff == 0) ? 64'd0 : ((64'd1 << (8 * eff)) - 64'd1);
        am   = {32'd0, a} & mask;
        bm   = {32'd0, b} & mask;
        if (!op) begin
            r       = am + bm;
            e.carry = EN && (eff != 0) && (((r >> (8 * eff)) & 64'd1) == 64'd1);
        end else begin
            r       = am - bm;
            e.carry = EN && (am < bm);
        end
        e.res  = 32'(r & mask);
        e.zero = (e.res == 32'd0);
        e.lat  = (eff == 0) ? 2 : eff + 2 + EXTRA;
        e.acc  = acc;
        return e;
    endfunction

    // ---- consumer ready driver (changes just after the clock edge) ----
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_rdy) rsp_ready = 1'b0;
            else if (force_rdy) rsp_ready = 1'b1;
            else rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---- monitor ----
    initial begin
        bit   prev;
        bit   rdy_next;
        exp_t e;
        prev = 1'b0;
        rdy_next = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
                rdy_next = 1'b0;
            end else begin
                if (rdy_next) begin
                    chk("req_ready_after_rsp", req_ready, 1);
                    rdy_next = 1'b0;
                end
                if (!busy) chk("idle_alu_op", alu_op, 0);
                if (rsp_valid) begin
                    if (sbq.size() == 0) begin
                        fail_now("unexpected_rsp");
                    end else begin
                        e = sbq[0];
                        chk("rsp_result", rsp_result, e.res);
                        chk("rsp_zero", rsp_zero, e.zero);
                        chk("rsp_carry", rsp_carry, e.carry);
                        chk("done_req_ready", req_ready, 0);
                        chk("done_busy", busy, 1);
                        chk("done_alu_op", alu_op, 0);
                        if (!prev) chk("latency", cyc - e.acc + 1, e.lat);
                        if (rsp_ready) begin
                            void'(sbq.pop_front());
                            rdy_next = 1'b1;
                        end
                    end
                end
                prev = rsp_valid;
            end
        end
    end

    // ---- stimulus ----
    task automatic issue(input bit op, input int len, input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            // Junk requests while busy must be ignored.
            req_valid = 1'($urandom_range(0, 1));
            req_op    = 1'($urandom_range(0, 1));
            req_len   = LW'($urandom_range(0, 7));
            req_a     = $urandom;
            req_b     = $urandom;
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            fail_now("req_ready_timeout");
            req_valid = 1'b0;
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_len   = LW'(len);
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        sbq.push_back(model(op, len, a, b, cyc));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            fail_now("drain_timeout");
            sbq.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rsp_result"}, rsp_result, 0);
        chk({tag, "_rsp_zero"}, rsp_zero, 0);
        chk({tag, "_rsp_carry"}, rsp_carry, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_alu_dat_a"}, alu_dat_a, 0);
        chk({tag, "_alu_dat_b"}, alu_dat_b, 0);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = 1'b0;
        req_len = '0;
        req_a = 32'd0;
        req_b = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        chk("alu_imm", alu_imm, 0);
        rst_n = 1'b1;

        // T1..T4 directed cases
        issue(1'b0, 2, 32'h0000_01FF, 32'h0000_0001);
        issue(1'b0, 4, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(1'b1, 4, 32'h0000_0000, 32'h0000_0001);
        issue(1'b0, 1, 32'h0000_0003, 32'h0000_0004);
        issue(1'b0, 0, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(1'b1, 0, 32'h0000_0000, 32'h0000_0001);
        issue(1'b0, 7, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(1'b1, 7, 32'h1000_0000, 32'h2000_0000);
        drain();

        // T5: backpressure in DONE for 5 cycles
        hold_rdy = 1'b1;
        issue(1'b0, 2, 32'hAAAA_01FF, 32'h5555_0001);
        t = 0;
        while (!rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) fail_now("t5_rsp_timeout");
        repeat (5) @(negedge clk);
        chk("t5_hold_valid", rsp_valid, 1);
        hold_rdy = 1'b0;
        force_rdy = 1'b1;
        drain();
        force_rdy = 1'b0;

        // T6: reset during BYTE at idx=1
        issue(1'b0, 4, 32'h0102_0304, 32'h1111_1111);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 4, 32'h0102_0304, 32'h1111_1111);
        drain();

        // Randomized traffic with random consumer backpressure
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: a = 32'hFFFF_FFFF;
                1: b = 32'h0000_0000;
                2: b = a;
                default: a = a;
            endcase
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), a, b);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
